// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU scheduler: opcodes, FSM
// encoding, request payload and requester-id helpers.
package alu_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ID_W    = 1;
    localparam int unsigned OPC_W   = 8;
    localparam int unsigned DATA_W  = 64;

    // ALU opcode map
    localparam logic [OPC_W-1:0] OP_ADD = 8'h00;
    localparam logic [OPC_W-1:0] OP_SUB = 8'h01;
    localparam logic [OPC_W-1:0] OP_AND = 8'h02;
    localparam logic [OPC_W-1:0] OP_MUL = 8'h03;
    localparam logic [OPC_W-1:0] OP_DIV = 8'h04;
    localparam logic [OPC_W-1:0] OP_OR  = 8'h05;
    localparam logic [OPC_W-1:0] OP_XOR = 8'h06;
    localparam logic [OPC_W-1:0] OP_SLL = 8'h07;
    localparam logic [OPC_W-1:0] OP_SRL = 8'h08;
    localparam logic [OPC_W-1:0] OP_SRA = 8'h09;
    localparam logic [OPC_W-1:0] OP_SLT = 8'h0A;
    localparam logic [OPC_W-1:0] OP_LUI = 8'h0B;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // One requester's operation as seen by the scheduler
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } alu_req_t;

    // Requester index to one-hot per-requester vector
    function automatic logic [NUM_REQ-1:0] id2oh(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter: a lone valid requester wins outright; when
// both are valid the one that did not win last time is chosen.
module alu_rr_arb
    import alu_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    grant_id_c
);

    // Grant selection from the current valid vector and the previous winner
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        case (valid)
            2'b01: begin
                grant_c    = 2'b01;
                grant_id_c = ID_W'(0);
            end
            2'b10: begin
                grant_c    = 2'b10;
                grant_id_c = ID_W'(1);
            end
            2'b11: begin
                grant_id_c = ~last_grant;
                grant_c    = id2oh(~last_grant);
            end
            default: begin
                grant_c    = '0;
                grant_id_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one multi-cycle 64-bit ALU between the core issue stage
// (requester 0) and the aux/debug unit (requester 1). Accepts one request,
// pulses alu_en once, waits an opcode-dependent latency, captures the result
// and returns it to the originating requester over valid/ready.
// Optional build macro ALU_DIVZERO_CHK_EN: a DIV with op2 == 0 is answered
// directly from IDLE with an all-ones result and rsp_err set, without
// touching the ALU.
module alu_sched
    import alu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*OPC_W-1:0]    req_opcode,
    input  logic [NUM_REQ*DATA_W-1:0]   req_op1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_op2,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_result,
    output logic                        rsp_err,
    output logic                        alu_en,
    output logic [OPC_W-1:0]            alu_opcode,
    output logic [DATA_W-1:0]           alu_op1,
    output logic [DATA_W-1:0]           alu_op2,
    input  logic [DATA_W-1:0]           alu_result,
    output logic                        busy
);

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    id;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic               div0_c;
    alu_req_t           sel;
    logic [CNT_W-1:0]   lat_c;

    alu_rr_arb u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant_c    (grant),
        .grant_id_c (grant_id)
    );

    // Requests are only offered a grant while idle and out of reset
    assign req_ready = (state == S_IDLE && rst_n) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign busy      = (state != S_IDLE);

    // Payload of the granted requester
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.opcode = req_opcode[i*OPC_W +: OPC_W];
                sel.op1    = req_op1[i*DATA_W +: DATA_W];
                sel.op2    = req_op2[i*DATA_W +: DATA_W];
            end
        end
    end

    // Short-circuit of divide-by-zero before it reaches the ALU
`ifdef ALU_DIVZERO_CHK_EN
    assign div0_c = (sel.opcode == OP_DIV) && (sel.op2 == DATA_W'(0));
`else
    assign div0_c = 1'b0;
`endif

    // Wait length for the opcode currently held on the ALU inputs
    always_comb begin
        lat_c = CNT_W'(1);
        if (alu_opcode == OP_MUL) begin
            lat_c = CNT_W'(MUL_LAT);
        end else if (alu_opcode == OP_DIV) begin
            lat_c = CNT_W'(DIV_LAT);
        end
    end

    // Scheduler FSM with operand latch, latency counter and response register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= ID_W'(1);
            id         <= '0;
            cnt        <= '0;
            alu_en     <= 1'b0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        id         <= grant_id;
                        last_grant <= grant_id;
                        if (div0_c) begin
                            rsp_valid  <= id2oh(grant_id);
                            rsp_result <= '1;
                            rsp_err    <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            alu_opcode <= sel.opcode;
                            alu_op1    <= sel.op1;
                            alu_op2    <= sel.op2;
                            alu_en     <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    alu_en <= 1'b0;
                    cnt    <= lat_c;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= id2oh(id);
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (|(rsp_valid & rsp_ready)) begin
                        rsp_valid <= '0;
                        rsp_err   <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural ALU model.
// Time reference: "delay" values are edge counts between the accept edge T and
// the edge after which a signal is first seen high (sampled on the falling
// edge); delay d therefore corresponds to cycle T+d+1.
module tb_alu_sched;
    import alu_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*OPC_W-1:0]  req_opcode;
    logic [NUM_REQ*DATA_W-1:0] req_op1;
    logic [NUM_REQ*DATA_W-1:0] req_op2;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_err;
    logic                      alu_en;
    logic [OPC_W-1:0]          alu_opcode;
    logic [DATA_W-1:0]         alu_op1;
    logic [DATA_W-1:0]         alu_op2;
    logic [DATA_W-1:0]         alu_result;
    logic                      busy;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int en_pulses = 0;

    alu_sched #(.MUL_LAT(4), .DIV_LAT(16), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_en     (alu_en),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (alu_en === 1'b1) en_pulses <= en_pulses + 1;

    // Behavioural ALU: computes when it sees en high at a rising edge
    always @(posedge clk) begin
        if (alu_en === 1'b1) begin
            case (alu_opcode)
                OP_ADD:  alu_result <= alu_op1 + alu_op2;
                OP_SUB:  alu_result <= alu_op1 - alu_op2;
                OP_MUL:  alu_result <= alu_op1 * alu_op2;
                OP_DIV:  alu_result <= (alu_op2 == 64'd0) ? 64'hDEAD_BEEF : alu_op1 / alu_op2;
                default: alu_result <= 64'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full single transaction from requester id; called on a falling edge
    task automatic run_op(input string tag, input int id, input logic [7:0] opc,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input logic exp_err,
                          input int exp_dly, input int exp_pulses, input int stall);
        int t_acc, t_en, t_rsp, p0, drops, unstable;
        logic got;
        logic [63:0] en_op1;
        logic [NUM_REQ-1:0] oh;
        oh = 2'b01 << id;
        got = 1'b0; t_en = -100; t_rsp = -100; drops = 0; unstable = 0; en_op1 = '0;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_opcode[id*8 +: 8] = opc;
        req_op1[id*64 +: 64]  = a;
        req_op2[id*64 +: 64]  = b;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready === oh) got = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_accept"}, 64'(got), 64'd1);
        t_acc = cyc;
        p0 = en_pulses;
        // Drop and scramble the request: the latched copy must be used
        req_valid = '0;
        req_op1 = '1;
        req_op2 = '1;
        req_opcode = '1;
        for (int k = 0; k < 40; k++) begin
            if (alu_en === 1'b1 && t_en < 0) begin
                t_en = cyc;
                en_op1 = alu_op1;
            end
            if (busy !== 1'b1) drops++;
            if (rsp_valid !== 2'b00) begin
                t_rsp = cyc;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_rsp_delay"}, 64'(t_rsp - t_acc), 64'(exp_dly));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
        chk({tag, "_result"}, rsp_result, exp_res);
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        chk({tag, "_busy_held"}, 64'(drops), 64'd0);
        if (exp_pulses > 0) begin
            chk({tag, "_en_delay"}, 64'(t_en - t_acc), 64'd0);
            chk({tag, "_alu_op1"}, en_op1, a);
        end
        for (int s = 0; s < stall; s++) begin
            rsp_ready = (s % 2 == 1) ? (oh ^ 2'b11) : 2'b00;
            @(negedge clk);
            if (rsp_valid !== oh || rsp_result !== exp_res || busy !== 1'b1) unstable++;
        end
        if (stall > 0) chk({tag, "_stall_stable"}, 64'(unstable), 64'd0);
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = '0;
        chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_en_pulses"}, 64'(en_pulses - p0), 64'(exp_pulses));
    endtask

    initial begin
        int gid, viol, drops, quiet;
        logic [63:0] rr_exp [4];
        int rr_gid [4];
        rr_exp = '{64'd3, 64'd7, 64'd3, 64'd7};
        rr_gid = '{0, 1, 0, 1};

        rst_n = 1'b0;
        req_valid = 2'b01;
        req_opcode = '0;
        req_op1 = '0;
        req_op2 = '0;
        rsp_ready = '0;
        repeat (3) @(negedge clk);

        // Reset state, with a request already pending
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_alu_en", 64'(alu_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
        chk("rst_alu_op1", alu_op1, 64'd0);
        chk("rst_alu_op2", alu_op2, 64'd0);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle, MUL and DIV latencies (delay = L+1)
        run_op("add", 0, OP_ADD, 64'd5, 64'd7, 64'd12, 1'b0, 2, 1, 0);
        run_op("mul", 0, OP_MUL, 64'd3, 64'd4, 64'd12, 1'b0, 5, 1, 0);
        run_op("div", 0, OP_DIV, 64'd100, 64'd7, 64'd14, 1'b0, 17, 1, 0);
        // Undefined opcode falls back to single-cycle latency
        run_op("undef", 1, 8'hF0, 64'd1, 64'd1, 64'd0, 1'b0, 2, 1, 0);
        // Response held 10 cycles, other requester's ready toggled meanwhile
        run_op("stall", 0, OP_ADD, 64'd20, 64'd22, 64'd42, 1'b0, 2, 1, 10);

        // Reset while a DIV is waiting on the ALU
        req_valid = 2'b01;
        req_opcode[7:0] = OP_DIV;
        req_op1[63:0] = 64'd50;
        req_op2[63:0] = 64'd5;
        #1;
        chk("rstw_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        chk("rstw_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_busy", 64'(busy), 64'd0);
        chk("rstw_alu_en", 64'(alu_en), 64'd0);
        chk("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstw_rsp_result", rsp_result, 64'd0);
        chk("rstw_alu_op1", alu_op1, 64'd0);
        chk("rstw_alu_opcode", 64'(alu_opcode), 64'd0);
        rst_n = 1'b1;
        quiet = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00 || busy !== 1'b0) quiet++;
        end
        chk("rstw_no_response", 64'(quiet), 64'd0);

        // Both requesters always valid: alternating grants, none while busy
        req_opcode = {OP_SUB, OP_ADD};
        req_op1 = {64'd10, 64'd1};
        req_op2 = {64'd3, 64'd2};
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        viol = 0;
        for (int n = 0; n < 4; n++) begin
            gid = -1;
            drops = 0;
            for (int k = 0; k < 40 && gid < 0; k++) begin
                #1;
                if (busy === 1'b1 && req_ready !== 2'b00) viol++;
                if (req_ready === 2'b01) gid = 0;
                else if (req_ready === 2'b10) gid = 1;
                @(negedge clk);
            end
            chk($sformatf("rr_grant%0d", n), 64'(gid), 64'(rr_gid[n]));
            for (int k = 0; k < 40; k++) begin
                if (busy !== 1'b1) drops++;
                if (req_ready !== 2'b00) viol++;
                if (rsp_valid !== 2'b00) break;
                @(negedge clk);
            end
            chk($sformatf("rr_result%0d", n), rsp_result, rr_exp[n]);
            chk($sformatf("rr_rsp_valid%0d", n), 64'(rsp_valid), 64'(2'b01 << rr_gid[n]));
            chk($sformatf("rr_busy%0d", n), 64'(drops), 64'd0);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '0;
        chk("rr_no_accept_busy", 64'(viol), 64'd0);
        @(negedge clk);

        // Divide by zero
`ifdef ALU_DIVZERO_CHK_EN
        run_op("div0", 1, OP_DIV, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 0, 0);
`else
        run_op("div0", 1, OP_DIV, 64'd9, 64'd0, 64'hDEAD_BEEF, 1'b0, 17, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
